key_search_checker: RTL and testbench

//   Parametrised successor to the single-core plaintext checker in the RC4 key-search datapath.
//   - Owns the key under test and an internal character index; no external k counter is needed.
//   - Validates each decrypted byte against a selectable character class.
//   - Steps keys by KEY_STEP from KEY_OFFSET, so N instances can search disjoint key slices in parallel.
//   - A shared halt input stops all instances once any one of them finds the key.

---
 rtl/key_search_checker.sv | 183 ++++++++++++++++++
 tb/tb_key_search_checker.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/key_search_checker.sv
// +----------------------------------------------------------------------------+
// | key_search_checker: RC4 key-search plaintext checker with sliced key walk. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module key_search_checker #(
    parameter int               KEY_W      = 24,
    parameter logic [KEY_W-1:0] KEY_OFFSET = '0,
    parameter logic [KEY_W-1:0] KEY_STEP   = {{(KEY_W-1){1'b0}}, 1'b1},
    parameter logic [KEY_W-1:0] KEY_MAX    = KEY_W'(24'h3FFFFF),
    parameter int               MSG_LEN    = 32,
    parameter int               CHAR_MODE  = 0
) (
    input  logic             clok,
    input  logic             resetm,
    input  logic             start,
    input  logic             halt,
    input  logic             char_valid,
    input  logic [7:0]       char_recieved,
    output logic             new_key,
    output logic             start_over,
    output logic             char_ok,
    output logic [KEY_W-1:0] key,
    output logic [7:0]       char_idx,
    output logic [KEY_W-1:0] keys_tried,
    output logic             found_key,
    output logic             last_key,
    output logic             done,
    output logic [2:0]       LEDS
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LAUNCH    = 3'd1,
        WAIT_CHAR = 3'd2,
        CHECK     = 3'd3,
        NEXT_KEY  = 3'd4,
        FOUND     = 3'd5,
        EXHAUSTED = 3'd6,
        HALTED    = 3'd7
    } state_t;

    localparam logic [7:0] LAST_IDX = 8'(MSG_LEN - 1);

    state_t           state_q;
    logic [7:0]       byte_q;
    logic [KEY_W-1:0] key_q;
    logic [7:0]       char_idx_q;
    logic [KEY_W-1:0] keys_tried_q;
    logic             new_key_q;
    logic             start_over_q;
    logic             char_ok_q;
    logic             found_q;
    logic             last_q;
    logic             halted_q;
    logic             done_q;

    // One extra bit so a step past the top of the key space is seen as overflow.
    logic [KEY_W:0]   key_sum_d;
    logic             byte_pass_d;
    logic             is_lower_d;
    logic             is_upper_d;
    logic             is_space_d;
    logic             is_print_d;
    logic             active_d;

    assign key_sum_d = {1'b0, key_q} + {1'b0, KEY_STEP};

    always_comb begin
        is_lower_d  = (byte_q >= 8'h61) && (byte_q <= 8'h7A);
        is_upper_d  = (byte_q >= 8'h41) && (byte_q <= 8'h5A);
        is_space_d  = (byte_q == 8'h20);
        is_print_d  = (byte_q >= 8'h20) && (byte_q <= 8'h7E);
        byte_pass_d = is_lower_d || is_space_d;
        if (CHAR_MODE == 1) begin
            byte_pass_d = is_print_d;
        end else if (CHAR_MODE == 2) begin
            byte_pass_d = is_lower_d || is_space_d || is_upper_d;
        end
    end

    assign active_d = (state_q == LAUNCH) || (state_q == WAIT_CHAR) ||
                      (state_q == CHECK)  || (state_q == NEXT_KEY);

    always_ff @(posedge clok or posedge resetm) begin
        if (resetm) begin
            state_q      <= IDLE;
            byte_q       <= '0;
            key_q        <= KEY_OFFSET;
            char_idx_q   <= '0;
            keys_tried_q <= '0;
            new_key_q    <= 1'b0;
            start_over_q <= 1'b0;
            char_ok_q    <= 1'b0;
            found_q      <= 1'b0;
            last_q       <= 1'b0;
            halted_q     <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            new_key_q    <= 1'b0;
            start_over_q <= 1'b0;
            char_ok_q    <= 1'b0;
            if (halt && active_d) begin
                state_q  <= HALTED;
                halted_q <= 1'b1;
                done_q   <= 1'b1;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start) begin
                            state_q <= LAUNCH;
                        end
                    end
                    LAUNCH: begin
                        key_q        <= KEY_OFFSET;
                        char_idx_q   <= '0;
                        new_key_q    <= 1'b1;
                        start_over_q <= 1'b1;
                        state_q      <= WAIT_CHAR;
                    end
                    WAIT_CHAR: begin
                        if (char_valid) begin
                            byte_q  <= char_recieved;
                            state_q <= CHECK;
                        end
                    end
                    CHECK: begin
                        if (byte_pass_d) begin
                            char_ok_q <= 1'b1;
                            if (char_idx_q == LAST_IDX) begin
                                found_q <= 1'b1;
                                done_q  <= 1'b1;
                                state_q <= FOUND;
                            end else begin
                                char_idx_q <= char_idx_q + 8'd1;
                                state_q    <= WAIT_CHAR;
                            end
                        end else begin
                            state_q <= NEXT_KEY;
                        end
                    end
                    NEXT_KEY: begin
                        if (keys_tried_q != '1) begin
                            keys_tried_q <= keys_tried_q + 1'b1;
                        end
                        if (key_sum_d > {1'b0, KEY_MAX}) begin
                            last_q  <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= EXHAUSTED;
                        end else begin
                            key_q        <= key_sum_d[KEY_W-1:0];
                            char_idx_q   <= '0;
                            new_key_q    <= 1'b1;
                            start_over_q <= 1'b1;
                            state_q      <= WAIT_CHAR;
                        end
                    end
                    FOUND, EXHAUSTED, HALTED: begin
                        state_q <= state_q;
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign new_key    = new_key_q;
    assign start_over = start_over_q;
    assign char_ok    = char_ok_q;
    assign key        = key_q;
    assign char_idx   = char_idx_q;
    assign keys_tried = keys_tried_q;
    assign found_key  = found_q;
    assign last_key   = last_q;
    assign done       = done_q;
    assign LEDS       = {halted_q, last_q, found_q};

endmodule

`default_nettype wire

// File: tb/tb_key_search_checker.sv
// +----------------------------------------------------------------------------+
// | tb_key_search_checker: directed bench for key_search_checker.              |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_key_search_checker;

    logic        clok;
    logic        resetm;
    logic        st   [3];
    logic        hlt  [3];
    logic        cv   [3];
    logic [7:0]  ch   [3];
    logic        nk   [3];
    logic        so   [3];
    logic        cok  [3];
    logic [23:0] key  [3];
    logic [7:0]  idx  [3];
    logic [23:0] kt   [3];
    logic        fnd  [3];
    logic        lst  [3];
    logic        dn   [3];
    logic [2:0]  leds [3];

    int errs   = 0;
    int checks = 0;

    // u0: mode 0, 4-byte message, default key range
    key_search_checker #(
        .KEY_W(24), .KEY_OFFSET(24'd0), .KEY_STEP(24'd1), .KEY_MAX(24'h3FFFFF),
        .MSG_LEN(4), .CHAR_MODE(0)
    ) u0 (
        .clok(clok), .resetm(resetm), .start(st[0]), .halt(hlt[0]),
        .char_valid(cv[0]), .char_recieved(ch[0]), .new_key(nk[0]), .start_over(so[0]),
        .char_ok(cok[0]), .key(key[0]), .char_idx(idx[0]), .keys_tried(kt[0]),
        .found_key(fnd[0]), .last_key(lst[0]), .done(dn[0]), .LEDS(leds[0])
    );

    // u1: mode 2, 8-byte message, slice starting at 5
    key_search_checker #(
        .KEY_W(24), .KEY_OFFSET(24'd5), .KEY_STEP(24'd1), .KEY_MAX(24'h3FFFFF),
        .MSG_LEN(8), .CHAR_MODE(2)
    ) u1 (
        .clok(clok), .resetm(resetm), .start(st[1]), .halt(hlt[1]),
        .char_valid(cv[1]), .char_recieved(ch[1]), .new_key(nk[1]), .start_over(so[1]),
        .char_ok(cok[1]), .key(key[1]), .char_idx(idx[1]), .keys_tried(kt[1]),
        .found_key(fnd[1]), .last_key(lst[1]), .done(dn[1]), .LEDS(leds[1])
    );

    // u2: multi-core slice 2, 6 within 0..9
    key_search_checker #(
        .KEY_W(24), .KEY_OFFSET(24'd2), .KEY_STEP(24'd4), .KEY_MAX(24'd9),
        .MSG_LEN(4), .CHAR_MODE(0)
    ) u2 (
        .clok(clok), .resetm(resetm), .start(st[2]), .halt(hlt[2]),
        .char_valid(cv[2]), .char_recieved(ch[2]), .new_key(nk[2]), .start_over(so[2]),
        .char_ok(cok[2]), .key(key[2]), .char_idx(idx[2]), .keys_tried(kt[2]),
        .found_key(fnd[2]), .last_key(lst[2]), .done(dn[2]), .LEDS(leds[2])
    );

    initial begin
        clok = 1'b0;
        forever #5 clok = ~clok;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clok);
        #1;
    endtask

    task automatic do_reset();
        resetm = 1'b1;
        tick();
        resetm = 1'b0;
        tick();
    endtask

    // After this the LAUNCH edge has passed and the new_key pulse is visible.
    task automatic go(input int d);
        st[d] = 1'b1;
        tick();
        st[d] = 1'b0;
        tick();
    endtask

    // After this the CHECK edge has passed; char_ok reflects the byte.
    task automatic send(input int d, input logic [7:0] c);
        cv[d] = 1'b1;
        ch[d] = c;
        tick();
        cv[d] = 1'b0;
        tick();
    endtask

    initial begin
        resetm = 1'b0;
        for (int i = 0; i < 3; i++) begin
            st[i] = 1'b0; hlt[i] = 1'b0; cv[i] = 1'b0; ch[i] = 8'h00;
        end
        #2;
        do_reset();

        chk("rst_key0",   key[0], 0);
        chk("rst_key1",   key[1], 5);
        chk("rst_idx",    idx[0], 0);
        chk("rst_tried",  kt[0],  0);
        chk("rst_done",   dn[0],  0);
        chk("rst_leds",   leds[0], 0);
        chk("rst_newkey", nk[0],  0);

        hlt[0] = 1'b1;
        tick();
        hlt[0] = 1'b0;
        chk("idle_halt_ignored", dn[0], 0);

        // "ab c" is accepted byte by byte and finds key 0
        go(0);
        chk("launch_newkey", nk[0], 1);
        chk("launch_sover",  so[0], 1);
        send(0, "a"); chk("t1_ok_a", cok[0], 1); chk("t1_idx1", idx[0], 1);
        send(0, "b"); chk("t1_ok_b", cok[0], 1); chk("t1_idx2", idx[0], 2);
        send(0, " "); chk("t1_ok_sp", cok[0], 1); chk("t1_idx3", idx[0], 3);
        send(0, "c"); chk("t1_ok_c", cok[0], 1);
        chk("t1_found", fnd[0], 1);
        chk("t1_done",  dn[0],  1);
        chk("t1_leds",  leds[0], 3'b001);
        chk("t1_key",   key[0], 0);
        chk("t1_tried", kt[0],  0);
        tick();
        chk("t1_ok_pulse", cok[0], 0);

        // 'Q' at idx 2 rejects key 0; new key two edges after char_valid is taken
        do_reset();
        go(0);
        send(0, "a");
        send(0, "b");
        send(0, "Q");
        chk("t2_ok_q",    cok[0], 0);
        chk("t2_nk_early", nk[0], 0);
        tick();
        chk("t2_newkey", nk[0], 1);
        chk("t2_sover",  so[0], 1);
        chk("t2_key",    key[0], 1);
        chk("t2_idx",    idx[0], 0);
        chk("t2_tried",  kt[0],  1);
        tick();
        chk("t2_nk_pulse", nk[0], 0);

        // halt beats the final passing CHECK
        do_reset();
        go(0);
        send(0, "a");
        send(0, "b");
        send(0, " ");
        cv[0] = 1'b1; ch[0] = "d";
        tick();
        cv[0] = 1'b0;
        hlt[0] = 1'b1;
        tick();
        hlt[0] = 1'b0;
        chk("t5_ok",    cok[0], 0);
        chk("t5_found", fnd[0], 0);
        chk("t5_done",  dn[0],  1);
        chk("t5_leds",  leds[0], 3'b100);

        // Mode 2 takes 'Q'; then an async reset lands mid-message
        do_reset();
        go(1);
        chk("t3_key5", key[1], 5);
        send(1, "1");
        tick();
        chk("t3_key6", key[1], 6);
        send(1, "a");
        send(1, "b");
        send(1, "Q");
        chk("t3_ok_Q",  cok[1], 1);
        chk("t3_idx3",  idx[1], 3);
        send(1, "R");
        send(1, "s");
        chk("t6_idx5", idx[1], 5);
        tick();
        resetm = 1'b1;
        #2;
        chk("t6_key",   key[1], 5);
        chk("t6_idx",   idx[1], 0);
        chk("t6_tried", kt[1],  0);
        chk("t6_leds",  leds[1], 0);
        chk("t6_done",  dn[1],  0);
        tick();
        resetm = 1'b0;
        tick();
        send(1, "a");
        chk("t6_idle_ok",  cok[1], 0);
        chk("t6_idle_idx", idx[1], 0);

        // Slice 2, 6 of 0..9: both fail, 6+4 overflows the slice
        go(2);
        chk("t4_key2", key[2], 2);
        send(2, "Q");
        tick();
        chk("t4_key6",   key[2], 6);
        chk("t4_nk",     nk[2],  1);
        chk("t4_tried1", kt[2],  1);
        send(2, "Q");
        tick();
        chk("t4_last",   lst[2], 1);
        chk("t4_done",   dn[2],  1);
        chk("t4_leds",   leds[2], 3'b010);
        chk("t4_keyend", key[2], 6);
        chk("t4_tried2", kt[2],  2);
        chk("t4_nk_end", nk[2],  0);
        go(2);
        chk("t4_start_ign_key", key[2], 6);
        chk("t4_start_ign_nk",  nk[2],  0);
        chk("t4_start_ign_led", leds[2], 3'b010);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

`default_nettype wire
